// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement magnitude: negate when the operand is negative.
  // Callers zero-extend a narrower operand and keep the low bits; the low
  // bits of a wide negation equal the narrow negation.
  function automatic logic [MAX_WIDTH-1:0] twos_mag(input logic [MAX_WIDTH-1:0] v,
                                                     input logic                 neg);
    return neg ? (~v + MAX_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/seq_mult_add.sv
// WIDTH-bit ripple adder with carry-out, used for the accumulate step.
module seq_mult_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with valid/ready on operands and result.
// Signed operands are converted to magnitudes, multiplied unsigned, and the
// sign is applied in a dedicated FIX cycle so latency does not depend on mode.
// Optional build macro: SEQ_MULT_EARLY_TERM_EN -- leave CALC as soon as the
// remaining multiplier bits are all zero (variable latency, same product).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// CALC  | one multiplier bit per cycle: conditional add, shift right
// FIX   | apply sign to the magnitude product
// DONE  | product presented with out_valid until out_ready
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    preg;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [PW-1:0]    shifted;

  assign mag_a = WIDTH'(twos_mag(MAX_WIDTH'(a), signed_mode & a[WIDTH-1]));
  assign mag_b = WIDTH'(twos_mag(MAX_WIDTH'(b), signed_mode & b[WIDTH-1]));

  seq_mult_add #(.WIDTH(WIDTH)) u_add (
    .a    (preg[PW-1:WIDTH]),
    .b    (mcand),
    .sum  (sum),
    .cout (cout)
  );

  // Next partial product: add mcand when the current multiplier bit is set, then shift right.
  always_comb begin
    shifted = {1'b0, preg[PW-1:1]};
    if (preg[0]) begin
      shifted = {cout, sum, preg[WIDTH-1:1]};
    end
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic             rem_zero;

  // Multiplier bits still to be processed occupy the low cnt bits of preg.
  always_comb begin
    rem_mask = ~({WIDTH{1'b1}} << cnt);
    rem_zero = ((preg[WIDTH-1:0] & rem_mask) == '0);
  end
`endif

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      preg      <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= mag_a;
            preg     <= {{WIDTH{1'b0}}, mag_b};
            cnt      <= CNT_W'(WIDTH);
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
          if (rem_zero) begin
            // No adds remain; finish the outstanding shifts in one step.
            preg  <= preg >> cnt;
            cnt   <= '0;
            state <= FIX;
          end else
`endif
          begin
            preg <= shifted;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          product   <= neg ? (~preg + PW'(1)) : preg;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            product   <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param (WIDTH=8): directed cases, backpressure,
// mid-operation reset and randomized traffic against an arithmetic reference.
module tb_seq_mult_param;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  logic force_rdy;
  logic force_val;
  logic rnd_rdy = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [2*W-1:0] p;
    int             k;
    int             lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  assign out_ready = force_rdy ? force_val : rnd_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rnd_rdy = 1'($urandom_range(0, 1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sm);
    int xi;
    int yi;
    if (sm) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    return (2*W)'(xi * yi);
  endfunction

  // Edges from acceptance until out_valid is visible.
  function automatic int exp_lat(input logic [W-1:0] y, input logic sm);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int yi;
    int m;
    int h;
    int calc;
    yi = sm ? int'($signed(y)) : int'(y);
    m  = (yi < 0) ? -yi : yi;
    h  = -1;
    for (int i = 0; i < W; i++) begin
      if (((m >> i) & 1) == 1) h = i;
    end
    if (h < 0)           calc = 1;
    else if (h == W - 1) calc = W;
    else                 calc = h + 2;
    return calc + 1;
`else
    return W + 1;
`endif
  endfunction

  // Monitor: pop the scoreboard on each new result, then watch it stay stable.
  logic           seen = 1'b0;
  logic [2*W-1:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (!seen) begin
        seen = 1'b1;
        held = product;
        if (sb.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = sb.pop_front();
          chk("product", 32'(product), 32'(e.p));
          chk("latency", 32'(cyc - e.k), 32'(e.lat));
          chk("busy_in_done", 32'(busy), 32'd0);
          chk("in_ready_in_done", 32'(in_ready), 32'd0);
        end
      end else begin
        chk("product_hold", 32'(product), 32'(held));
      end
    end else begin
      seen = 1'b0;
      chk("product_zero_when_invalid", 32'(product), 32'd0);
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1) begin
      in_valid    = 1'($urandom_range(0, 1));
      a           = W'($urandom);
      b           = W'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      n++;
      if (n > 200) begin
        in_valid = 1'b0;
        fail_now("in_ready_timeout");
        return;
      end
      @(negedge clk);
    end
    a           = x;
    b           = y;
    signed_mode = sm;
    in_valid    = 1'b1;
    sb.push_back('{ref_mul(x, y, sm), cyc + 1, exp_lat(y, sm)});
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("drain_timeout");
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;
    force_rdy   = 1'b1;
    force_val   = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    rst = 1'b0;

    // Directed products.
    issue(8'd13, 8'd11, 1'b0);
    drain();
    issue(8'd255, 8'd255, 1'b0);
    issue(8'hFD, 8'd5, 1'b1);
    issue(8'h80, 8'h80, 1'b1);
    issue(8'd0, 8'h5A, 1'b1);
    issue(8'hC3, 8'd0, 1'b0);
    drain();

    // Backpressure: result held for 5 cycles, in_valid pulses ignored.
    force_val = 1'b0;
    issue(8'h2C, 8'h13, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("backpressure_valid_timeout");
    repeat (5) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    force_val = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    drain();

    // Reset during the 4th CALC cycle aborts silently.
    issue(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    issue(8'd7, 8'd6, 1'b0);
    drain();

    // Short multiplier: early exit when enabled, full latency otherwise.
    issue(8'd3, 8'd1, 1'b0);
    drain();

    // Randomized traffic with random consumer backpressure.
    force_rdy = 1'b0;
    repeat (40) begin
      case ($urandom_range(0, 5))
        0: x = 8'h00;
        1: x = 8'h80;
        2: x = 8'hFF;
        3: x = 8'h7F;
        default: x = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: y = 8'h00;
        1: y = 8'h80;
        2: y = 8'h01;
        3: y = 8'hFF;
        default: y = W'($urandom);
      endcase
      issue(x, y, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    force_rdy = 1'b1;
    force_val = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
